vend_credit_fsm: RTL and testbench

Parametrised coin-credit controller for the coffee vending machine. It accumulates validated coin values into a saturating credit register and compares the credit against a configurable price. When the price is met, it handshakes with the dispenser and then returns any change. It also handles customer cancel and an inactivity timeout with a full refund, and drives the Yellow/Green status LEDs.

---
 rtl/vend_credit_fsm_if.sv | 39 +++
 rtl/vend_credit_fsm.sv | 191 +++++++++++++++++++
 tb/tb_vend_credit_fsm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_credit_fsm_if.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm_if
// Bundles the coin/cancel/dispenser/change signals of the coin-credit
// controller.
//   master : the machine side (coin acceptor, keypad, dispenser, payout).
//            Drives coin_valid, coin, cancel, dispenser_ready and change_ack,
//            and observes the controller outputs.
//   slave  : the credit controller. Drives dispenser, change_valid, change,
//            coin_reject, credit, LED_Yellow and LED_Green.
// ---------------------------------------------------------------------------
interface vend_credit_fsm_if #(
  parameter int COIN_W   = 4,
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [COIN_W-1:0]   coin;
  logic                cancel;
  logic                dispenser_ready;
  logic                change_ack;
  logic                dispenser;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                LED_Yellow;
  logic                LED_Green;

  modport master (
    output coin_valid, coin, cancel, dispenser_ready, change_ack,
    input  dispenser, change_valid, change, coin_reject, credit,
           LED_Yellow, LED_Green
  );

  modport slave (
    input  coin_valid, coin, cancel, dispenser_ready, change_ack,
    output dispenser, change_valid, change, coin_reject, credit,
           LED_Yellow, LED_Green
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// vend_credit_fsm
// Coin-credit controller for the coffee vending machine. It accumulates
// accepted coins into a saturating credit register and vends once the credit
// reaches PRICE. After the vend it pays back any excess credit. A customer
// cancel or an idle timeout in COLLECT refunds the whole credit.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active low
//   bus  : vend_credit_fsm_if.slave
//     coin_valid/coin   : coin strobe and value. A coin of value 0 is ignored.
//     cancel            : refund request. Honoured only in COLLECT.
//     dispenser_ready   : the dispenser can start a vend
//     change_ack        : payout finished. Honoured only in RETURN.
//     dispenser         : vend command, high for DISP_CYCLES cycles
//     change_valid      : change holds an amount to pay out
//     change            : payout amount
//     coin_reject       : one-cycle pulse for a coin that was not credited
//     credit            : current credit
//     LED_Yellow        : vend in progress (WAIT_DISP, DISPENSE)
//     LED_Green         : idle, ready for coins
// All outputs are registered.
// ---------------------------------------------------------------------------
module vend_credit_fsm #(
  parameter int COIN_W      = 4,
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 5,
  parameter int TIMEOUT     = 255,
  parameter int DISP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  vend_credit_fsm_if.slave   bus
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int PCNT_W = $clog2(DISP_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] LP_PRICE   = CREDIT_W'(PRICE);
  localparam logic [TMR_W-1:0]    LP_TMR_END = TMR_W'(TIMEOUT - 1);
  localparam logic [PCNT_W-1:0]   LP_PCNT_LD = PCNT_W'(DISP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_DISP,
    DISPENSE,
    RETURN
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change;
  logic                r_change_valid;
  logic                r_dispenser;
  logic                r_coin_reject;
  logic                r_led_yellow;
  logic                r_led_green;
  logic [TMR_W-1:0]    r_timer;
  logic [PCNT_W-1:0]   r_pcnt;

  logic                w_accept;
  logic [CREDIT_W-1:0] w_coin_ext;
  logic [CREDIT_W-1:0] w_sum;

  // Credit + coin with one guard bit; an overflow clamps to all ones.
  function automatic logic [CREDIT_W-1:0] sat_add(
    input logic [CREDIT_W-1:0] a,
    input logic [COIN_W-1:0]   b
  );
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + (CREDIT_W+1)'(b);
    return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
  endfunction

  assign w_accept   = bus.coin_valid && (bus.coin != '0);
  assign w_coin_ext = CREDIT_W'(bus.coin);
  assign w_sum      = sat_add(r_credit, bus.coin);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_change       <= '0;
      r_change_valid <= 1'b0;
      r_dispenser    <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_led_yellow   <= 1'b0;
      r_led_green    <= 1'b1;
      r_timer        <= '0;
      r_pcnt         <= '0;
    end else begin
      r_coin_reject <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_credit    <= w_coin_ext;
            r_timer     <= '0;
            r_led_green <= 1'b0;
            if (w_coin_ext >= LP_PRICE) begin
              r_state      <= WAIT_DISP;
              r_led_yellow <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (bus.cancel) begin
            // Cancel wins over a coin in the same cycle; that coin bounces.
            r_state        <= RETURN;
            r_change       <= r_credit;
            r_change_valid <= 1'b1;
            r_coin_reject  <= w_accept;
          end else if (w_accept) begin
            r_credit <= w_sum;
            r_timer  <= '0;
            if (w_sum >= LP_PRICE) begin
              r_state      <= WAIT_DISP;
              r_led_yellow <= 1'b1;
            end
          end else if (r_timer == LP_TMR_END) begin
            r_state        <= RETURN;
            r_change       <= r_credit;
            r_change_valid <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        WAIT_DISP: begin
          r_coin_reject <= w_accept;
          if (bus.dispenser_ready) begin
            r_state     <= DISPENSE;
            r_dispenser <= 1'b1;
            r_pcnt      <= LP_PCNT_LD;
          end
        end

        DISPENSE: begin
          r_coin_reject <= w_accept;
          if (r_pcnt == '0) begin
            // Pulse over: drop dispenser on the same edge the next state's
            // indicator rises.
            r_dispenser  <= 1'b0;
            r_led_yellow <= 1'b0;
            if (r_credit > LP_PRICE) begin
              r_state        <= RETURN;
              r_change       <= r_credit - LP_PRICE;
              r_change_valid <= 1'b1;
            end else begin
              r_state     <= IDLE;
              r_credit    <= '0;
              r_led_green <= 1'b1;
            end
          end else begin
            r_pcnt <= r_pcnt - PCNT_W'(1);
          end
        end

        RETURN: begin
          r_coin_reject <= w_accept;
          if (bus.change_ack) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_led_green    <= 1'b1;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_led_green  <= 1'b1;
          r_led_yellow <= 1'b0;
          r_dispenser  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dispenser    = r_dispenser;
  assign bus.change_valid = r_change_valid;
  assign bus.change       = r_change;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.credit       = r_credit;
  assign bus.LED_Yellow   = r_led_yellow;
  assign bus.LED_Green    = r_led_green;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_fsm
// Directed bench for vend_credit_fsm. Three instances share clk/rst:
//   uA : default parameters
//   uB : TIMEOUT = 16
//   uC : CREDIT_W = 4 (saturation case)
// Inputs change 1 ns after a rising edge. Outputs are sampled at that point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vend_credit_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_credit_fsm_if #(.COIN_W(4), .CREDIT_W(8)) ifA ();
  vend_credit_fsm_if #(.COIN_W(4), .CREDIT_W(8)) ifB ();
  vend_credit_fsm_if #(.COIN_W(4), .CREDIT_W(4)) ifC ();

  vend_credit_fsm uA (.clk(clk), .rst(rst), .bus(ifA));
  vend_credit_fsm #(.TIMEOUT(16)) uB (.clk(clk), .rst(rst), .bus(ifB));
  vend_credit_fsm #(.CREDIT_W(4)) uC (.clk(clk), .rst(rst), .bus(ifC));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifA.coin_valid = 0; ifA.coin = 0; ifA.cancel = 0; ifA.dispenser_ready = 0; ifA.change_ack = 0;
    ifB.coin_valid = 0; ifB.coin = 0; ifB.cancel = 0; ifB.dispenser_ready = 0; ifB.change_ack = 0;
    ifC.coin_valid = 0; ifC.coin = 0; ifC.cancel = 0; ifC.dispenser_ready = 0; ifC.change_ack = 0;

    // Reset values
    rst = 0;
    tick(); tick();
    chk("rst_credit", ifA.credit, 0);
    chk("rst_change", ifA.change, 0);
    chk("rst_cv", ifA.change_valid, 0);
    chk("rst_disp", ifA.dispenser, 0);
    chk("rst_rej", ifA.coin_reject, 0);
    chk("rst_ledy", ifA.LED_Yellow, 0);
    chk("rst_ledg", ifA.LED_Green, 1);
    chk("rst_ledg_B", ifB.LED_Green, 1);
    chk("rst_ledg_C", ifC.LED_Green, 1);
    rst = 1;
    tick();

    // Zero coin and cancel in IDLE do nothing
    ifA.coin_valid = 1; ifA.coin = 0; ifA.cancel = 1;
    tick();
    ifA.coin_valid = 0; ifA.cancel = 0;
    chk("zero_credit", ifA.credit, 0);
    chk("zero_ledg", ifA.LED_Green, 1);
    chk("zero_rej", ifA.coin_reject, 0);
    chk("idle_cancel_cv", ifA.change_valid, 0);

    // Coins 2 then 3, exact price, no change
    ifA.dispenser_ready = 1;
    ifA.coin_valid = 1; ifA.coin = 2;
    tick();
    chk("t1_credit2", ifA.credit, 2);
    chk("t1_ledg_off", ifA.LED_Green, 0);
    chk("t1_ledy_collect", ifA.LED_Yellow, 0);
    ifA.coin = 3;
    tick();
    ifA.coin_valid = 0;
    chk("t1_credit5", ifA.credit, 5);
    chk("t1_ledy_wait", ifA.LED_Yellow, 1);
    chk("t1_disp_wait", ifA.dispenser, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_disp_hi%0d", i), ifA.dispenser, 1);
    end
    chk("t1_ledy_disp", ifA.LED_Yellow, 1);
    tick();
    chk("t1_disp_lo", ifA.dispenser, 0);
    chk("t1_ledg_back", ifA.LED_Green, 1);
    chk("t1_ledy_off", ifA.LED_Yellow, 0);
    chk("t1_no_cv", ifA.change_valid, 0);
    chk("t1_credit0", ifA.credit, 0);

    // Coins 2, 2, 4 -> credit 8, change 3
    ifA.coin_valid = 1; ifA.coin = 2;
    tick();
    tick();
    chk("t2_credit4", ifA.credit, 4);
    ifA.coin = 4;
    tick();
    ifA.coin_valid = 0;
    chk("t2_credit8", ifA.credit, 8);
    chk("t2_ledy", ifA.LED_Yellow, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t2_disp_last", ifA.dispenser, 1);
    tick();
    chk("t2_disp_lo", ifA.dispenser, 0);
    chk("t2_cv", ifA.change_valid, 1);
    chk("t2_change", ifA.change, 3);
    chk("t2_ledg_ret", ifA.LED_Green, 0);
    chk("t2_ledy_ret", ifA.LED_Yellow, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t2_hold_cv%0d", i), ifA.change_valid, 1);
      chk($sformatf("t2_hold_chg%0d", i), ifA.change, 3);
    end
    ifA.change_ack = 1;
    tick();
    ifA.change_ack = 0;
    chk("t2_ack_cv", ifA.change_valid, 0);
    chk("t2_ack_change", ifA.change, 0);
    chk("t2_ack_credit", ifA.credit, 0);
    chk("t2_ack_ledg", ifA.LED_Green, 1);

    // Coin 3, then cancel with a coin in the same cycle
    ifA.dispenser_ready = 0;
    ifA.coin_valid = 1; ifA.coin = 3;
    tick();
    chk("t3_credit3", ifA.credit, 3);
    ifA.coin = 1; ifA.cancel = 1;
    tick();
    ifA.coin_valid = 0; ifA.cancel = 0;
    chk("t3_cv", ifA.change_valid, 1);
    chk("t3_change", ifA.change, 3);
    chk("t3_rej_hi", ifA.coin_reject, 1);
    chk("t3_credit_kept", ifA.credit, 3);
    tick();
    chk("t3_rej_lo", ifA.coin_reject, 0);
    chk("t3_disp", ifA.dispenser, 0);
    ifA.change_ack = 1;
    tick();
    ifA.change_ack = 0;
    chk("t3_idle", ifA.LED_Green, 1);
    chk("t3_disp_end", ifA.dispenser, 0);

    // Timeout on uB: coin 1, refund 16 cycles later
    ifB.coin_valid = 1; ifB.coin = 1;
    tick();
    ifB.coin_valid = 0;
    chk("t4_credit1", ifB.credit, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_cv_early", ifB.change_valid, 0);
    tick();
    chk("t4_cv", ifB.change_valid, 1);
    chk("t4_change", ifB.change, 1);
    ifB.coin_valid = 1; ifB.coin = 2;
    tick();
    ifB.coin_valid = 0;
    chk("t4_rej_hi", ifB.coin_reject, 1);
    chk("t4_credit_kept", ifB.credit, 1);
    chk("t4_change_hold", ifB.change, 1);
    tick();
    chk("t4_rej_lo", ifB.coin_reject, 0);
    ifB.change_ack = 1;
    tick();
    ifB.change_ack = 0;
    chk("t4_idle", ifB.LED_Green, 1);

    // Saturation on uC (CREDIT_W=4): 4 + 15 -> 15, change 10
    ifC.coin_valid = 1; ifC.coin = 4;
    tick();
    chk("t5_credit4", ifC.credit, 4);
    ifC.coin = 15;
    tick();
    ifC.coin_valid = 0;
    chk("t5_sat", ifC.credit, 15);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t5_wait_ledy%0d", i), ifC.LED_Yellow, 1);
      chk($sformatf("t5_wait_disp%0d", i), ifC.dispenser, 0);
    end
    ifC.dispenser_ready = 1;
    tick();
    chk("t5_disp", ifC.dispenser, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_cv", ifC.change_valid, 1);
    chk("t5_change", ifC.change, 10);
    ifC.change_ack = 1;
    tick();
    ifC.change_ack = 0;
    chk("t5_idle", ifC.LED_Green, 1);

    // Reset during DISPENSE on uA
    ifA.dispenser_ready = 1;
    ifA.coin_valid = 1; ifA.coin = 5;
    tick();
    ifA.coin_valid = 0;
    chk("t6_wait", ifA.LED_Yellow, 1);
    tick();
    tick();
    chk("t6_disp", ifA.dispenser, 1);
    rst = 0;
    tick();
    rst = 1;
    chk("t6_disp_rst", ifA.dispenser, 0);
    chk("t6_credit_rst", ifA.credit, 0);
    chk("t6_change_rst", ifA.change, 0);
    chk("t6_cv_rst", ifA.change_valid, 0);
    chk("t6_ledy_rst", ifA.LED_Yellow, 0);
    chk("t6_ledg_rst", ifA.LED_Green, 1);
    tick();
    chk("t6_stay_idle", ifA.dispenser, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
